writeback_stage: RTL and testbench
==================================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; SHALL be >= 32.
REQ-002 Parameter REG_AW, default 5, destination register index width.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 stall_i  input  1  hold the W register contents.
REQ-006 flush_i  input  1  kill the instruction entering W.
REQ-007 ValidM  input  1  M-stage holds a real instruction.
REQ-008 RegWriteM  input  1  instruction writes the register file.
REQ-009 ResultSrcM  input  2  result select: 00 ALU, 01 load, 10 PC+4, 11 immediate.
REQ-010 Funct3M  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-011 ALUResultM  input  WIDTH  ALU result; also the load address.
REQ-012 ReadDataM  input  WIDTH  raw data-memory word.
REQ-013 RdM  input  REG_AW  destination register index.
REQ-014 PCPlus4M  input  WIDTH  link value.
REQ-015 ImmExtM  input  WIDTH  extended immediate (LUI).
REQ-016 RegWriteW  output  1  register-file write enable.
REQ-017 RdW  output  REG_AW  register-file write index.
REQ-018 ResultW  output  WIDTH  register-file write data.
REQ-019 ValidW  output  1  W holds a live instruction.
REQ-020 MisalignW  output  1  W holds a misaligned load.

Function
REQ-021 M-to-W register SHALL capture all M inputs on the clk edge when rst_n=1, stall_i=0 and flush_i=0, giving 1-cycle latency from M inputs to W outputs.
REQ-022 flush_i=1 SHALL clear the registered valid and RegWrite bits on the next edge; flush_i SHALL take priority over stall_i.
REQ-023 stall_i=1 with flush_i=0 SHALL hold every W register bit unchanged, including valid.
REQ-024 ResultW SHALL be combinational from W registers: ALUResultW, load value, PCPlus4W or ImmExtW per ResultSrcW.
REQ-025 Load value: byte offset = ALUResultW[1:0]; LB/LBU SHALL select byte lane offset; LH/LHU SHALL select halfword lane offset[1]; LW SHALL select ReadDataW[31:0].
REQ-026 LB/LH/LW SHALL sign-extend to WIDTH; LBU/LHU SHALL zero-extend; reserved Funct3 codes SHALL produce LW behaviour.
REQ-027 MisalignW SHALL be 1 iff ValidW=1, ResultSrcW=01 and (LH/LHU with offset[0]=1, or LW with offset!=0).
REQ-028 RegWriteW SHALL equal ValidW AND RegWrite registered AND RdW!=0 AND NOT MisalignW.
REQ-029 Funct3 SHALL be ignored when ResultSrcW!=01.
REQ-030 ValidW SHALL reflect the registered ValidM; an instruction with ValidM=0 SHALL never write.

Reset
REQ-031 rst_n=0 at a clk edge SHALL clear all W registers; after that edge ValidW=0, RegWriteW=0, MisalignW=0, RdW=0, ResultW=0.
REQ-032 Reset SHALL override stall_i and flush_i, including mid-stall.

Configuration
REQ-033 Macro WB_INSTRET_EN defined: SHALL add output InstretW (64 bits), a retired-instruction counter.
REQ-034 InstretW SHALL reset to 0, SHALL increment by 1 on each edge where ValidW=1, MisalignW=0 and stall_i=0, and SHALL wrap from all-ones to 0.
REQ-035 Macro undefined: port InstretW and the counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-036 LB: ReadDataM=0x8000_7F80, ALUResultM=0x1000_0000, Rd=5, ResultSrc=01 -> next cycle ResultW=0xFFFF_FF80, RegWriteW=1, RdW=5.
REQ-037 LHU: offset 2, ReadDataM=0xBEEF_1234 -> ResultW=0x0000_BEEF; LW at offset 1 -> MisalignW=1, RegWriteW=0.
REQ-038 Rd=0, RegWriteM=1, ALU result 0x55 -> ResultW=0x55, RegWriteW=0.
REQ-039 stall_i=1 for 3 cycles with changing M inputs -> W outputs constant; flush_i+stall_i together -> ValidW=0 next cycle.
REQ-040 rst_n=0 during stall with live instruction in W -> next cycle all outputs 0; with WB_INSTRET_EN, 10 valid aligned retires -> InstretW=10, and preload 0xFFFF_FFFF_FFFF_FFFF plus one retire -> InstretW=0.

Source files
------------

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - M-to-W pipeline register, load extraction/extension and result select.
// Optional retired-instruction counter InstretW when WB_INSTRET_EN is defined.
module writeback_stage #(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              ValidM,
    input  logic              RegWriteM,
    input  logic [1:0]        ResultSrcM,
    input  logic [2:0]        Funct3M,
    input  logic [WIDTH-1:0]  ALUResultM,
    input  logic [WIDTH-1:0]  ReadDataM,
    input  logic [REG_AW-1:0] RdM,
    input  logic [WIDTH-1:0]  PCPlus4M,
    input  logic [WIDTH-1:0]  ImmExtM,
`ifdef WB_INSTRET_EN
    output logic [63:0]       InstretW,
`endif
    output logic              RegWriteW,
    output logic [REG_AW-1:0] RdW,
    output logic [WIDTH-1:0]  ResultW,
    output logic              ValidW,
    output logic              MisalignW
);

    logic              valid_w;
    logic              regwrite_w;
    logic [1:0]        resultsrc_w;
    logic [2:0]        funct3_w;
    logic [WIDTH-1:0]  aluresult_w;
    logic [WIDTH-1:0]  readdata_w;
    logic [REG_AW-1:0] rd_w;
    logic [WIDTH-1:0]  pcplus4_w;
    logic [WIDTH-1:0]  immext_w;

    // Flush only kills valid/RegWrite; the payload bits are simply not reloaded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_w     <= 1'b0;
            regwrite_w  <= 1'b0;
            resultsrc_w <= '0;
            funct3_w    <= '0;
            aluresult_w <= '0;
            readdata_w  <= '0;
            rd_w        <= '0;
            pcplus4_w   <= '0;
            immext_w    <= '0;
        end else if (flush_i) begin
            valid_w    <= 1'b0;
            regwrite_w <= 1'b0;
        end else if (!stall_i) begin
            valid_w     <= ValidM;
            regwrite_w  <= RegWriteM;
            resultsrc_w <= ResultSrcM;
            funct3_w    <= Funct3M;
            aluresult_w <= ALUResultM;
            readdata_w  <= ReadDataM;
            rd_w        <= RdM;
            pcplus4_w   <= PCPlus4M;
            immext_w    <= ImmExtM;
        end
    end

    logic [1:0]       offset;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [WIDTH-1:0] load_v;
    logic             is_half;
    logic             is_word;
    logic             misalign;

    always_comb begin
        offset = aluresult_w[1:0];
        case (offset)
            2'd0:    byte_v = readdata_w[7:0];
            2'd1:    byte_v = readdata_w[15:8];
            2'd2:    byte_v = readdata_w[23:16];
            default: byte_v = readdata_w[31:24];
        endcase
        half_v = offset[1] ? readdata_w[31:16] : readdata_w[15:0];

        // Reserved Funct3 codes fall through to word behaviour, including alignment.
        is_half = 1'b0;
        is_word = 1'b0;
        case (funct3_w)
            3'b000:  load_v = WIDTH'($signed(byte_v));
            3'b100:  load_v = WIDTH'(byte_v);
            3'b001: begin
                load_v  = WIDTH'($signed(half_v));
                is_half = 1'b1;
            end
            3'b101: begin
                load_v  = WIDTH'(half_v);
                is_half = 1'b1;
            end
            default: begin
                load_v  = WIDTH'($signed(readdata_w[31:0]));
                is_word = 1'b1;
            end
        endcase

        misalign = valid_w && (resultsrc_w == 2'b01) &&
                   ((is_half && offset[0]) || (is_word && (offset != 2'd0)));

        case (resultsrc_w)
            2'b00:   ResultW = aluresult_w;
            2'b01:   ResultW = load_v;
            2'b10:   ResultW = pcplus4_w;
            default: ResultW = immext_w;
        endcase
    end

    assign ValidW    = valid_w;
    assign RdW       = rd_w;
    assign MisalignW = misalign;
    assign RegWriteW = valid_w && regwrite_w && (rd_w != '0) && !misalign;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            instret_q <= '0;
        else if (valid_w && !misalign && !stall_i)
            instret_q <= instret_q + 64'd1;
    end

    assign InstretW = instret_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - directed scoreboard bench for writeback_stage.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall_i, flush_i;
    logic        ValidM, RegWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, ReadDataM, PCPlus4M, ImmExtM;
    logic [4:0]  RdM;
    logic        RegWriteW, ValidW, MisalignW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
`ifdef WB_INSTRET_EN
    logic [63:0] InstretW;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        v;
        logic        mis;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    writeback_stage #(.WIDTH(32), .REG_AW(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .ValidM     (ValidM),
        .RegWriteM  (RegWriteM),
        .ResultSrcM (ResultSrcM),
        .Funct3M    (Funct3M),
        .ALUResultM (ALUResultM),
        .ReadDataM  (ReadDataM),
        .RdM        (RdM),
        .PCPlus4M   (PCPlus4M),
        .ImmExtM    (ImmExtM),
`ifdef WB_INSTRET_EN
        .InstretW   (InstretW),
`endif
        .RegWriteW  (RegWriteW),
        .RdW        (RdW),
        .ResultW    (ResultW),
        .ValidW     (ValidW),
        .MisalignW  (MisalignW)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, expv);
        end
    endtask

    task automatic set_m(input logic v, input logic rw, input logic [1:0] src,
                         input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] rdata, input logic [4:0] rd);
        ValidM     = v;
        RegWriteM  = rw;
        ResultSrcM = src;
        Funct3M    = f3;
        ALUResultM = alu;
        ReadDataM  = rdata;
        RdM        = rd;
        PCPlus4M   = 32'h0000_2004;
        ImmExtM    = 32'hABCD_E000;
    endtask

    // Expectation pushed when stimulus is driven, popped one edge later.
    task automatic step(input string tag, input logic rw, input logic [4:0] rd,
                        input logic [31:0] res, input logic v, input logic mis);
        exp_t e;
        e.tag = tag; e.rw = rw; e.rd = rd; e.res = res; e.v = v; e.mis = mis;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".RegWriteW"}, 64'(RegWriteW), 64'(e.rw));
        chk({e.tag, ".RdW"},       64'(RdW),       64'(e.rd));
        chk({e.tag, ".ResultW"},   64'(ResultW),   64'(e.res));
        chk({e.tag, ".ValidW"},    64'(ValidW),    64'(e.v));
        chk({e.tag, ".MisalignW"}, 64'(MisalignW), 64'(e.mis));
    endtask

    initial begin
        rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        set_m(1, 1, 2'b01, 3'b010, 32'h0000_0100, 32'hFFFF_FFFF, 5'd9);
        @(posedge clk); #1;
        step("reset", 0, 0, 32'h0, 0, 0);
        rst_n = 1'b1;

        set_m(1, 1, 2'b01, 3'b000, 32'h1000_0000, 32'h8000_7F80, 5'd5);
        step("lb_off0", 1, 5, 32'hFFFF_FF80, 1, 0);
        set_m(1, 1, 2'b01, 3'b000, 32'h1000_0001, 32'h8000_7F80, 5'd5);
        step("lb_off1", 1, 5, 32'h0000_007F, 1, 0);
        set_m(1, 1, 2'b01, 3'b100, 32'h1000_0003, 32'h8000_7F80, 5'd6);
        step("lbu_off3", 1, 6, 32'h0000_0080, 1, 0);
        set_m(1, 1, 2'b01, 3'b000, 32'h1000_0003, 32'h8000_7F80, 5'd6);
        step("lb_off3", 1, 6, 32'hFFFF_FF80, 1, 0);
        set_m(1, 1, 2'b01, 3'b101, 32'h2000_0002, 32'hBEEF_1234, 5'd8);
        step("lhu_off2", 1, 8, 32'h0000_BEEF, 1, 0);
        set_m(1, 1, 2'b01, 3'b001, 32'h2000_0002, 32'hBEEF_1234, 5'd8);
        step("lh_off2", 1, 8, 32'hFFFF_BEEF, 1, 0);
        set_m(1, 1, 2'b01, 3'b001, 32'h2000_0000, 32'hBEEF_9234, 5'd8);
        step("lh_off0", 1, 8, 32'hFFFF_9234, 1, 0);
        set_m(1, 1, 2'b01, 3'b001, 32'h2000_0001, 32'hBEEF_1234, 5'd8);
        step("lh_mis", 0, 8, 32'h0000_1234, 1, 1);
        set_m(1, 1, 2'b01, 3'b010, 32'h2000_0001, 32'hBEEF_1234, 5'd3);
        step("lw_mis", 0, 3, 32'hBEEF_1234, 1, 1);
        set_m(1, 1, 2'b01, 3'b010, 32'h2000_0004, 32'hBEEF_1234, 5'd3);
        step("lw_ok", 1, 3, 32'hBEEF_1234, 1, 0);
        set_m(1, 1, 2'b01, 3'b111, 32'h2000_0000, 32'h8765_4321, 5'd4);
        step("rsvd_lw", 1, 4, 32'h8765_4321, 1, 0);
        set_m(1, 1, 2'b00, 3'b000, 32'h0000_0055, 32'h0, 5'd0);
        step("rd0", 0, 0, 32'h0000_0055, 1, 0);
        set_m(1, 1, 2'b00, 3'b010, 32'h0000_0055, 32'h0, 5'd1);
        step("alu_f3_ignored", 1, 1, 32'h0000_0055, 1, 0);
        set_m(1, 1, 2'b10, 3'b001, 32'h0000_0003, 32'h0, 5'd1);
        step("pcplus4", 1, 1, 32'h0000_2004, 1, 0);
        set_m(1, 1, 2'b11, 3'b010, 32'h0000_0001, 32'h0, 5'd2);
        step("imm", 1, 2, 32'hABCD_E000, 1, 0);
        set_m(0, 1, 2'b00, 3'b000, 32'h0000_0077, 32'h0, 5'd2);
        step("invalid", 0, 2, 32'h0000_0077, 0, 0);

        set_m(1, 1, 2'b01, 3'b010, 32'h0000_0100, 32'hCAFE_F00D, 5'd7);
        step("pre_stall", 1, 7, 32'hCAFE_F00D, 1, 0);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_m(1, 1, 2'b00, 3'b000, 32'h1111_0000 + 32'(i), 32'h0, 5'(10 + i));
            step("stall_hold", 1, 7, 32'hCAFE_F00D, 1, 0);
        end
        flush_i = 1'b1;
        step("flush_stall", 0, 7, 32'hCAFE_F00D, 0, 0);
        flush_i = 1'b0; stall_i = 1'b0;

        set_m(1, 1, 2'b00, 3'b000, 32'h0000_1234, 32'h0, 5'd12);
        step("pre_rst", 1, 12, 32'h0000_1234, 1, 0);
        stall_i = 1'b1; rst_n = 1'b0;
        step("rst_in_stall", 0, 0, 32'h0, 0, 0);
        stall_i = 1'b0; rst_n = 1'b1;

`ifdef WB_INSTRET_EN
        chk("instret_after_rst", InstretW, 64'd0);
        for (int i = 0; i < 10; i++) begin
            set_m(1, 1, 2'b00, 3'b000, 32'(i), 32'h0, 5'd1);
            @(posedge clk); #1;
        end
        set_m(0, 0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("instret_10", InstretW, 64'd10);
        dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        set_m(1, 1, 2'b00, 3'b000, 32'h1, 32'h0, 5'd1);
        @(posedge clk); #1;
        set_m(0, 0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
        @(posedge clk); #1;
        chk("instret_wrap", InstretW, 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
